// File: rtl/mips_pkg.sv
// Shared definitions for the decode-to-issue dispatcher: channel count, select
// width, skid-buffer occupancy states and the channel decode helper.
package mips_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_state_t;

  // One-hot channel mask for a select value.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_CH'(1) << sel;
  endfunction

endpackage

// File: rtl/demux1to4_pipe_if.sv
// Bus bundle for demux1to4_pipe: upstream valid/ready stream, four downstream
// channels, counter clear and the per-channel transfer counts.
interface demux1to4_pipe_if
  import mips_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) ();

  logic              valid_in;
  logic              ready_out;
  logic [SEL_W-1:0]  select_in;
  logic [W-1:0]      data_in;

  logic [NUM_CH-1:0] valid_out;
  logic [NUM_CH-1:0] ready_in;
  logic [W-1:0]      data0_out;
  logic [W-1:0]      data1_out;
  logic [W-1:0]      data2_out;
  logic [W-1:0]      data3_out;

  logic              clear_in;
  logic [CNT_W-1:0]  count0_out;
  logic [CNT_W-1:0]  count1_out;
  logic [CNT_W-1:0]  count2_out;
  logic [CNT_W-1:0]  count3_out;

  // Dispatcher side.
  modport slave (
    input  valid_in, select_in, data_in, ready_in, clear_in,
    output ready_out, valid_out,
    output data0_out, data1_out, data2_out, data3_out,
    output count0_out, count1_out, count2_out, count3_out
  );

  // Decode stage and issue ports side.
  modport master (
    output valid_in, select_in, data_in, ready_in, clear_in,
    input  ready_out, valid_out,
    input  data0_out, data1_out, data2_out, data3_out,
    input  count0_out, count1_out, count2_out, count3_out
  );

endinterface

// File: rtl/demux1to4_pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer with a registered upstream ready, so a
// full-rate stream never depends combinationally on downstream ready.
module skid_buffer
  import mips_pkg::*;
#(
  parameter int DW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  occ_state_t    state;
  logic [DW-1:0] head;
  logic [DW-1:0] skid;
  logic          accept;
  logic          drain;

  assign accept   = up_valid & up_ready;
  assign drain    = dn_valid & dn_ready;
  assign dn_valid = (state != OCC_EMPTY);
  assign dn_data  = head;

  // NOTE: state registers use non-blocking assignments only; the later
  // up_ready assignments in the case override the default on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OCC_EMPTY;
      up_ready <= 1'b0;
      head     <= '0;
      skid     <= '0;
    end else begin
      up_ready <= 1'b1;
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            head  <= up_data;
            state <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && !drain) begin
            skid     <= up_data;
            state    <= OCC_TWO;
            up_ready <= 1'b0;
          end else if (accept) begin
            head <= up_data;
          end else if (drain) begin
            state <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Upstream is stalled here, so only a drain can change anything.
          if (drain) begin
            head  <= skid;
            state <= OCC_ONE;
          end else begin
            up_ready <= 1'b0;
          end
        end
        default: begin
          state    <= OCC_EMPTY;
          up_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/demux1to4_pipe.sv
// Registered 1-to-4 dispatcher: buffers the decode stream and presents each
// word only on its selected issue channel, counting completed transfers.
module demux1to4_pipe
  import mips_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic           clk_in,
  input  logic           reset_n_in,
  demux1to4_pipe_if.slave bus
);

  localparam int DW = W + SEL_W;

  logic [DW-1:0]     up_word;
  logic [DW-1:0]     head_word;
  logic              head_valid;
  logic              head_ready;
  logic [SEL_W-1:0]  head_sel;
  logic [W-1:0]      head_data;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_drain;
  logic [W-1:0]      ch_data [NUM_CH];
  logic [CNT_W-1:0]  cnt     [NUM_CH];

  assign up_word = {bus.select_in, bus.data_in};

  skid_buffer #(.DW(DW)) u_skid (
    .clk      (clk_in),
    .rst_n    (reset_n_in),
    .up_valid (bus.valid_in),
    .up_ready (bus.ready_out),
    .up_data  (up_word),
    .dn_valid (head_valid),
    .dn_ready (head_ready),
    .dn_data  (head_word)
  );

  assign {head_sel, head_data} = head_word;

  // Only the selected channel's ready matters; the rest are ignored.
  assign head_ready = bus.ready_in[head_sel];
  assign ch_drain   = ch_valid & bus.ready_in;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ch_valid = '0;
    if (head_valid) ch_valid = sel_onehot(head_sel);
    for (int k = 0; k < NUM_CH; k++) begin
      ch_data[k] = ch_valid[k] ? head_data : '0;
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.clear_in) begin
          cnt[k] <= '0;
        end else if (ch_drain[k] && (cnt[k] != '1)) begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.valid_out  = ch_valid;
  assign bus.data0_out  = ch_data[0];
  assign bus.data1_out  = ch_data[1];
  assign bus.data2_out  = ch_data[2];
  assign bus.data3_out  = ch_data[3];
  assign bus.count0_out = cnt[0];
  assign bus.count1_out = cnt[1];
  assign bus.count2_out = cnt[2];
  assign bus.count3_out = cnt[3];

endmodule

// File: tb/tb_demux1to4_pipe.sv
// Directed bench for demux1to4_pipe: reset, single word, streaming,
// backpressure, head-of-line blocking, counter saturation and clear.
module tb_demux1to4_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] dq [4];
  logic [3:0]  cq [4];

  demux1to4_pipe_if #(.W(32), .CNT_W(4)) bus ();

  demux1to4_pipe #(.W(32), .CNT_W(4)) dut (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dq[0] = bus.data0_out;
  assign dq[1] = bus.data1_out;
  assign dq[2] = bus.data2_out;
  assign dq[3] = bus.data3_out;
  assign cq[0] = bus.count0_out;
  assign cq[1] = bus.count1_out;
  assign cq[2] = bus.count2_out;
  assign cq[3] = bus.count3_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] data);
    bus.valid_in  = 1'b1;
    bus.select_in = sel;
    bus.data_in   = data;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // 1: reset held with valid_in asserted
    rst_n        = 1'b0;
    bus.clear_in = 1'b0;
    bus.ready_in = 4'b0000;
    send(2'd0, 32'h1111_1111);
    repeat (3) tick();
    check("rst_ready", bus.ready_out, 1'b0);
    check("rst_valid", bus.valid_out, 4'b0000);
    check("rst_data0", dq[0], 32'h0);
    check("rst_counts", {cq[0], cq[1], cq[2], cq[3]}, 16'h0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_before_edge", bus.ready_out, 1'b0);
    tick();
    check("rel_ready_after_edge", bus.ready_out, 1'b1);
    check("rel_valid_after_edge", bus.valid_out, 4'b0000);
    bus.valid_in = 1'b0;
    tick();
    check("rel_nothing_accepted", bus.valid_out, 4'b0000);

    // 2: single word to channel 2
    bus.ready_in = 4'b1111;
    send(2'd2, 32'hDEAD_BEEF);
    tick();
    bus.valid_in = 1'b0;
    check("single_valid", bus.valid_out, 4'b0100);
    check("single_data2", dq[2], 32'hDEAD_BEEF);
    check("single_data0", dq[0], 32'h0);
    check("single_data3", dq[3], 32'h0);
    check("single_count_pre", cq[2], 4'd0);
    tick();
    check("single_count2", cq[2], 4'd1);
    check("single_empty", bus.valid_out, 4'b0000);

    // clear with no drain in progress
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    check("clear_idle", cq[2], 4'd0);

    // 3: streaming, one word per cycle across all channels
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stream_ready_%0d", i), bus.ready_out, 1'b1);
      send(2'(i % 4), 32'h100 + 32'(i));
      tick();
      check($sformatf("stream_valid_%0d", i), bus.valid_out, 4'b0001 << (i % 4));
      check($sformatf("stream_data_%0d", i), dq[i % 4], 32'h100 + 32'(i));
    end
    bus.valid_in = 1'b0;
    tick();
    check("stream_drained", bus.valid_out, 4'b0000);
    check("stream_counts", {cq[3], cq[2], cq[1], cq[0]}, 16'h2222);

    // 4: backpressure fills both entries and stalls the third word
    bus.ready_in = 4'b0000;
    send(2'd0, 32'hA0);
    tick();
    check("bp_a_valid", bus.valid_out, 4'b0001);
    check("bp_a_ready", bus.ready_out, 1'b1);
    send(2'd1, 32'hB1);
    tick();
    check("bp_full_ready", bus.ready_out, 1'b0);
    check("bp_full_head", dq[0], 32'hA0);
    send(2'd2, 32'hC2);
    tick();
    check("bp_held_ready", bus.ready_out, 1'b0);
    check("bp_held_valid", bus.valid_out, 4'b0001);
    check("bp_held_data", dq[0], 32'hA0);
    bus.ready_in = 4'b1111;
    tick();
    check("bp_b_valid", bus.valid_out, 4'b0010);
    check("bp_b_data", dq[1], 32'hB1);
    check("bp_b_ready", bus.ready_out, 1'b1);
    tick();
    bus.valid_in = 1'b0;
    check("bp_c_valid", bus.valid_out, 4'b0100);
    check("bp_c_data", dq[2], 32'hC2);
    tick();
    check("bp_empty", bus.valid_out, 4'b0000);
    check("bp_counts", {cq[3], cq[2], cq[1], cq[0]}, 16'h2333);

    // 5: head-of-line blocking, channel 3 waits behind stalled channel 1
    bus.ready_in = 4'b1000;
    send(2'd1, 32'h51);
    tick();
    check("hol_head", bus.valid_out, 4'b0010);
    send(2'd3, 32'h53);
    tick();
    bus.valid_in = 1'b0;
    check("hol_blocked_valid", bus.valid_out, 4'b0010);
    check("hol_blocked_data3", dq[3], 32'h0);
    tick();
    check("hol_still_blocked", bus.valid_out, 4'b0010);
    check("hol_count3_hold", cq[3], 4'd2);
    bus.ready_in = 4'b1010;
    tick();
    check("hol_ch3_valid", bus.valid_out, 4'b1000);
    check("hol_ch3_data", dq[3], 32'h53);
    check("hol_count1", cq[1], 4'd4);
    tick();
    check("hol_count3", cq[3], 4'd3);
    check("hol_empty", bus.valid_out, 4'b0000);

    // reset while a word is buffered discards it
    bus.ready_in = 4'b0000;
    send(2'd0, 32'h66);
    tick();
    bus.valid_in = 1'b0;
    check("mid_rst_pre", bus.valid_out, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.valid_out, 4'b0000);
    check("mid_rst_data0", dq[0], 32'h0);
    check("mid_rst_count1", cq[1], 4'd0);
    check("mid_rst_ready", bus.ready_out, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", bus.ready_out, 1'b1);
    check("post_rst_valid", bus.valid_out, 4'b0000);

    // 6: counter saturation at 15 then clear against a simultaneous drain
    bus.ready_in = 4'b1111;
    for (int i = 1; i <= 17; i++) begin
      send(2'd0, 32'(i));
      tick();
      if (i == 15) check("sat_count_14", cq[0], 4'd14);
    end
    bus.valid_in = 1'b0;
    tick();
    check("sat_count_15", cq[0], 4'd15);
    send(2'd0, 32'h77);
    tick();
    bus.valid_in = 1'b0;
    bus.clear_in = 1'b1;
    check("clr_drain_pre", bus.valid_out, 4'b0001);
    tick();
    bus.clear_in = 1'b0;
    check("clr_drain_count0", cq[0], 4'd0);
    check("clr_drain_empty", bus.valid_out, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
